// File: rtl/run_monitor.sv
// Run controller and cycle profiler for a compute core: launches a run, times it
// against a watchdog, keeps latency/run statistics and drives a hex-display value.
//
// state   | meaning
// IDLE    | waiting for the first start request
// LAUNCH  | one-cycle start pulse to the core, cycle counter cleared
// WAIT    | counting cycles until dut_done rises or the watchdog expires
// DONE    | last run succeeded; status held until the next launch
// TIMEOUT | last run hit the watchdog; status held until the next launch
module run_monitor #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32,
    parameter int RUN_W          = 8,
    parameter int DISP_W         = 24
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start_req,
    input  logic              continuous,
    output logic              dut_start,
    input  logic              dut_done,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  last_cycles,
    output logic [RUN_W-1:0]  run_count,
    output logic [RUN_W-1:0]  err_count,
    input  logic [1:0]        disp_sel,
    output logic [DISP_W-1:0] disp_value
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] min_cycles;
    logic [CNT_W-1:0] max_cycles;
    logic             done_q;
    logic             rise;
    logic             hit;
    logic             expire;

    assign n    = counter + CNT_W'(1);
    assign rise = dut_done & ~done_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dut_start = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        hit       = 1'b0;
        expire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_req) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                dut_start = 1'b1;
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // a completion in the watchdog's final cycle still counts as success
                if (rise) begin
                    hit       = 1'b1;
                    state_nxt = S_DONE;
                end else if (n == TIMEOUT_VAL) begin
                    expire    = 1'b1;
                    state_nxt = S_TIMEOUT;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start_req || continuous) state_nxt = S_LAUNCH;
            end
            S_TIMEOUT: begin
                timed_out = 1'b1;
                if (start_req || continuous) state_nxt = S_LAUNCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            done_q      <= 1'b0;
            counter     <= '0;
            last_cycles <= '0;
            min_cycles  <= '1;
            max_cycles  <= '0;
            run_count   <= '0;
            err_count   <= '0;
        end else begin
            done_q <= dut_done;
            if (state == S_LAUNCH) begin
                counter <= '0;
            end else if (state == S_WAIT && !hit && !expire) begin
                counter <= n;
            end
            if (hit) begin
                last_cycles <= n;
                if (n < min_cycles) min_cycles <= n;
                if (n > max_cycles) max_cycles <= n;
            end
            if (hit || expire) begin
                if (run_count != '1) run_count <= run_count + RUN_W'(1);
            end
            if (expire) begin
                if (err_count != '1) err_count <= err_count + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            disp_value <= '0;
        end else begin
            case (disp_sel)
                2'd0: disp_value <= DISP_W'(last_cycles);
                2'd1: disp_value <= DISP_W'(min_cycles);
                2'd2: disp_value <= DISP_W'(max_cycles);
                2'd3: disp_value <= DISP_W'({run_count, err_count});
            endcase
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: single runs, statistics, watchdog, held done level,
// continuous soak with saturation, and asynchronous reset mid-run.
module tb_run_monitor;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        start_req = 1'b0;
    logic        continuous = 1'b0;
    logic        dut_start;
    logic        dut_done = 1'b0;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [31:0] last_cycles;
    logic [7:0]  run_count;
    logic [7:0]  err_count;
    logic [1:0]  disp_sel = 2'd0;
    logic [23:0] disp_value;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit core_en = 1'b0;
    int core_lat = 4;

    run_monitor #(
        .TIMEOUT_CYCLES(1000),
        .CNT_W(32),
        .RUN_W(8),
        .DISP_W(24)
    ) dut (
        .clock(clock),
        .resetN(resetN),
        .start_req(start_req),
        .continuous(continuous),
        .dut_start(dut_start),
        .dut_done(dut_done),
        .busy(busy),
        .done(done),
        .timed_out(timed_out),
        .last_cycles(last_cycles),
        .run_count(run_count),
        .err_count(err_count),
        .disp_sel(disp_sel),
        .disp_value(disp_value)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // automatic core: one-cycle done pulse core_lat WAIT cycles after each launch
    initial begin
        forever begin
            @(negedge clock);
            if (core_en && dut_start) begin
                repeat (core_lat) @(posedge clock);
                #1 dut_done = 1'b1;
                @(posedge clock);
                #1 dut_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (dut_start) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start_req = 1'b1;
        @(negedge clock);
        start_req = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
    endtask

    task automatic run_manual(input int lat);
        bit ok;
        pulse_start();
        wait_start(5, ok);
        check("launch", ok, 1);
        @(negedge clock);
        check("start_width", dut_start, 0);
        repeat (lat - 1) @(posedge clock);
        #1 dut_done = 1'b1;
        @(posedge clock);
        #1 dut_done = 1'b0;
        @(negedge clock);
        check("done_flag", done, 1);
    endtask

    task automatic check_disp(input logic [1:0] sel, input logic [23:0] exp, input string tag);
        @(negedge clock);
        disp_sel = sel;
        @(negedge clock);
        check(tag, disp_value, exp);
    endtask

    initial begin
        bit ok;
        int prev;
        int bad_int;
        int misses;

        // reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_start", dut_start, 0);
        check("rst_last", last_cycles, 0);
        do_reset();
        check("rst_done", done, 0);
        check("rst_disp", disp_value, 0);

        // single run of latency 37
        run_manual(37);
        check("t1_last", last_cycles, 37);
        check("t1_runs", run_count, 1);
        check("t1_errs", err_count, 0);
        check("t1_busy", busy, 0);
        check_disp(2'd0, 24'h000025, "t1_disp0");

        // statistics over three runs
        do_reset();
        run_manual(10);
        run_manual(50);
        run_manual(20);
        check("t2_last", last_cycles, 20);
        check_disp(2'd1, 24'd10, "t2_min");
        check_disp(2'd2, 24'd50, "t2_max");
        check_disp(2'd3, 24'h000300, "t2_counts");

        // watchdog: no completion at all
        do_reset();
        pulse_start();
        wait_start(5, ok);
        check("t3_launch", ok, 1);
        repeat (1000) @(negedge clock);
        check("t3_not_yet", timed_out, 0);
        check("t3_still_busy", busy, 1);
        @(negedge clock);
        check("t3_timed_out", timed_out, 1);
        check("t3_errs", err_count, 1);
        check("t3_runs", run_count, 1);
        check("t3_last", last_cycles, 0);
        check_disp(2'd1, 24'hFFFFFF, "t3_min");
        check_disp(2'd2, 24'd0, "t3_max");

        // done held high through launch; only the later re-rise counts
        @(negedge clock);
        dut_done = 1'b1;
        pulse_start();
        wait_start(5, ok);
        check("t4_launch", ok, 1);
        @(negedge clock);
        repeat (2) @(posedge clock);
        #1 dut_done = 1'b0;
        repeat (2) @(posedge clock);
        #1 dut_done = 1'b1;
        @(posedge clock);
        #1 dut_done = 1'b0;
        @(negedge clock);
        check("t4_done", done, 1);
        check("t4_last", last_cycles, 5);
        check("t4_runs", run_count, 2);

        // continuous soak with fixed latency 4
        do_reset();
        core_lat = 4;
        core_en = 1'b1;
        continuous = 1'b1;
        bad_int = 0;
        misses = 0;
        prev = 0;
        pulse_start();
        for (int i = 0; i < 260; i++) begin
            wait_start(20, ok);
            if (!ok) misses++;
            if (i > 0 && (cyc - prev) != 6) bad_int++;
            prev = cyc;
            @(negedge clock);
        end
        continuous = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        core_en = 1'b0;
        check("t5_misses", misses, 0);
        check("t5_period", bad_int, 0);
        check("t5_settle", ok, 1);
        check("t5_runs_sat", run_count, 255);
        check("t5_errs", err_count, 0);
        check("t5_last", last_cycles, 4);

        // asynchronous reset in the middle of WAIT
        pulse_start();
        wait_start(5, ok);
        check("t6_launch", ok, 1);
        repeat (3) @(negedge clock);
        check("t6_busy_before", busy, 1);
        #1 resetN = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_start", dut_start, 0);
        check("t6_runs", run_count, 0);
        check("t6_last", last_cycles, 0);
        check("t6_disp", disp_value, 0);
        @(negedge clock);
        resetN = 1'b1;
        run_manual(7);
        check("t6_after_last", last_cycles, 7);
        check("t6_after_runs", run_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish before 2 ms");
        $fatal(1);
    end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
Synthesizable run controller and cycle profiler that sits between ChipInterface and a compute core such as the matrix multiplier. On request it launches the core with a one-cycle start pulse and counts cycles until the core's done signal rises. A watchdog aborts runs that exceed a cycle budget. It keeps last/min/max latency plus run and timeout counts, and muxes one of them onto a hex-display value bus. Continuous mode re-launches the core back-to-back for soak testing on the board.

Parameters:
TIMEOUT_CYCLES, 1000, WAIT cycles allowed before a run is declared timed out; must be >= 1.
CNT_W, 32, width of the cycle counter and latency registers; must hold TIMEOUT_CYCLES.
RUN_W, 8, width of the run and timeout counters; both saturate.
DISP_W, 24, display bus width (6 hex digits); must be >= 2*RUN_W.

Ports:
clock  input  1  system clock (CLOCK_50 domain)
resetN  input  1  asynchronous active-low reset
start_req  input  1  level/pulse request to launch a run
continuous  input  1  1 = auto re-launch after each finished run
dut_start  output  1  one-cycle start pulse to the core
dut_done  input  1  core completion flag, rising edge significant
busy  output  1  high in LAUNCH and WAIT
done  output  1  high in DONE state
timed_out  output  1  high in TIMEOUT state
last_cycles  output  CNT_W  latency of the most recent successful run
run_count  output  RUN_W  finished runs (success + timeout), saturating
err_count  output  RUN_W  timed-out runs, saturating
disp_sel  input  2  display source select
disp_value  output  DISP_W  selected value for hex decoders

Behaviour:
- Reset (async, resetN=0): state IDLE; dut_start, busy, done, timed_out = 0; last_cycles, max_cycles, run_count, err_count, counter = 0; min_cycles = all ones; done_q = 0.
- Edge detect: done_q <= dut_done every cycle in all states; rise = dut_done & ~done_q. A level already high at launch is not a rise.
- IDLE: start_req=1 -> LAUNCH.
- LAUNCH (exactly 1 cycle): dut_start=1, counter <= 0 -> WAIT.
- WAIT: each cycle, with n = counter+1:
  - rise -> last_cycles <= n; min/max updated; run_count++ -> DONE.
  - else if n == TIMEOUT_CYCLES -> run_count++, err_count++ -> TIMEOUT.
  - else counter <= n.
  - Rise and timeout in the same cycle: success wins.
  - Latency n counts WAIT cycles, inclusive of the rise cycle; a rise in the first WAIT cycle gives 1.
- DONE / TIMEOUT: status held.
  - start_req=1 -> LAUNCH.
  - else continuous=1 -> LAUNCH on the next cycle, so one cycle is spent in DONE/TIMEOUT.
  - start_req in LAUNCH/WAIT is ignored; it is not queued.
- Counters: run_count and err_count stop at 2^RUN_W-1. min/max are updated only on success; min stays all ones until the first success.
- disp_value is registered, 1-cycle latency from disp_sel/source, zero-extended to DISP_W:
  - 0 -> last_cycles[DISP_W-1:0]
  - 1 -> min_cycles
  - 2 -> max_cycles
  - 3 -> {run_count, err_count}
- Reset mid-run: immediate return to IDLE, dut_start drops, all statistics cleared.

Test Plan:
- Reset, start_req pulse, core raises dut_done 37 cycles after dut_start -> dut_start high exactly 1 cycle; done=1; last_cycles=37, run_count=1, err_count=0; disp_sel=0 gives disp_value=0x000025.
- Three runs of latency 10, 50, 20 -> last_cycles=20; disp_sel=1 gives 10, disp_sel=2 gives 50; disp_sel=3 gives 0x000300.
- dut_done never rises, TIMEOUT_CYCLES=1000 -> timed_out=1 exactly 1000 cycles after the WAIT entry cycle; err_count=1; min/max unchanged (min=all ones).
- dut_done held high through launch, then falls and re-rises after 5 cycles -> held level is not counted; last_cycles equals the WAIT cycles up to the re-rise.
- continuous=1, fixed latency 4 -> dut_start pulses every 6 cycles; after 255+ runs, run_count saturates at 255.
- resetN pulsed low mid-WAIT -> all outputs return to reset values asynchronously; a later start_req runs normally.
